div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 185 ++++++++++++++++++
 tb/tb_div_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential 32-bit integer divider for the MIPS-style execute stage.
// Handles div (signed) and divu (unsigned). It uses a restoring
// shift-subtract loop that runs for 32 cycles, plus a one-cycle path
// for a zero divisor.
// The quotient goes to LO and the remainder goes to HI.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        ready,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [5:0]  count;
  logic [64:0] work;
  logic [31:0] divisor;
  logic        signed_q;
  logic        dividend_neg;
  logic        divisor_neg;

  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [64:0] shifted;
  logic [33:0] trial;
  logic [64:0] step_work;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_final;
  logic [31:0] rem_final;
  logic        neg_quot;
  logic        neg_rem;

  // Work out the operand magnitudes that get latched when a request is accepted.
  // In signed mode each negative operand is replaced by its magnitude.
  // -2^31 maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    dividend_mag = opdata1;
    divisor_mag  = opdata2;
    if (signed_div && opdata1[31]) begin
      dividend_mag = 32'd0 - opdata1;
    end
    if (signed_div && opdata2[31]) begin
      divisor_mag = 32'd0 - opdata2;
    end
  end

  // Perform one restoring step on the 65-bit working register.
  // The upper 33 bits hold the partial remainder and the lower 32 bits hold
  // the dividend bits, which are replaced by quotient bits as they shift out.
  // The trial subtraction is 34 bits wide so that its sign bit shows a borrow.
  always_comb begin
    shifted   = {work[63:0], 1'b0};
    trial     = {1'b0, shifted[64:32]} - {2'b00, divisor};
    step_work = shifted;
    if (!trial[33]) begin
      step_work = {trial[32:0], shifted[31:1], 1'b1};
    end
  end

  // Apply the sign fix-up to the result of the final step.
  // The quotient is negated when the operand signs differ.
  // The remainder takes the sign of the dividend.
  always_comb begin
    quot_raw   = step_work[31:0];
    rem_raw    = step_work[63:32];
    neg_quot   = signed_q & (dividend_neg ^ divisor_neg);
    neg_rem    = signed_q & dividend_neg;
    quot_final = quot_raw;
    rem_final  = rem_raw;
    if (neg_quot) begin
      quot_final = 32'd0 - quot_raw;
    end
    if (neg_rem) begin
      rem_final = 32'd0 - rem_raw;
    end
  end

  // Select the next state. annul overrides every other condition, including
  // the final BUSY step, so a flushed divide never raises ready.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (opdata2 == 32'd0) begin
            state_next = DIVZERO;
          end else begin
            state_next = BUSY;
          end
        end
      end
      DIVZERO: begin
        state_next = DONE;
      end
      BUSY: begin
        if (count == 6'd31) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (annul) begin
      state_next = IDLE;
    end
  end

  // State register. ready is registered from the next state, so it is high
  // in exactly the cycles where the state is DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == DONE);
    end
  end

  // Operand latch and iteration datapath. The operands are captured only
  // when IDLE accepts a request, so input changes during BUSY have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work         <= 65'd0;
      divisor      <= 32'd0;
      count        <= 6'd0;
      signed_q     <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
    end else if (state == IDLE && state_next == BUSY) begin
      work         <= {33'd0, dividend_mag};
      divisor      <= divisor_mag;
      count        <= 6'd0;
      signed_q     <= signed_div;
      dividend_neg <= opdata1[31];
      divisor_neg  <= opdata2[31];
    end else if (state == BUSY && state_next != IDLE) begin
      work  <= step_work;
      count <= count + 6'd1;
    end
  end

  // Result registers. They are written only on entry to DONE and keep their
  // values through IDLE, annul and new operations until the next result is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_lo <= 32'd0;
      result_hi <= 32'd0;
    end else if (state == BUSY && state_next == DONE) begin
      result_lo <= quot_final;
      result_hi <= rem_final;
    end else if (state == DIVZERO && state_next == DONE) begin
      result_lo <= 32'd0;
      result_hi <= 32'd0;
    end
  end

  // Hold the pipeline from the request cycle until the cycle the result is valid.
  always_comb begin
    stall_req = start & ~ready;
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard testbench for div_seq. The driver pushes the expected result
// and latency for each request. A monitor pops an entry and compares it
// whenever ready rises.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        ready;
  logic        stall_req;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  logic ready_prev = 1'b0;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; cyc at a falling edge is the number of the preceding rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reportFailure(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: on each rise of ready, compare against the oldest expected entry.
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        reportFailure("unexpected_ready");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("quotient", result_lo, e.lo);
        checkOutput("remainder", result_hi, e.hi);
        checkOutput("latency_edges", 32'(cyc - e.start_edge + 1), 32'(e.lat));
      end
    end
    ready_prev <= ready;
  end

  // Issue one request, scramble the operand inputs while it runs, wait for ready,
  // hold start for some cycles, then release start and check that ready falls.
  // Latency is counted with the edge that samples start as edge 1.
  task automatic applyStimulus(input logic sg, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] elo, input logic [31:0] ehi,
                               input int lat, input int hold);
    logic stall_bad;
    int   waited;
    exp_t e;
    @(negedge clk);
    start      = 1'b1;
    signed_div = sg;
    opdata1    = a;
    opdata2    = b;
    e.lo = elo; e.hi = ehi; e.lat = lat; e.start_edge = cyc + 1;
    exp_q.push_back(e);
    #1;
    checkOutput("stall_at_request", {31'd0, stall_req}, 32'd1);
    @(posedge clk);
    #1;
    opdata1    = ~a;
    opdata2    = b ^ 32'h5A5A_0F0F;
    signed_div = ~sg;
    stall_bad  = 1'b0;
    waited     = 0;
    while (!ready && waited < 40) begin
      @(negedge clk);
      if (!ready && !stall_req) stall_bad = 1'b1;
      waited++;
    end
    if (!ready) begin
      reportFailure("ready_timeout");
      exp_q.delete();
      start = 1'b0;
      return;
    end
    checkOutput("stall_while_busy", {31'd0, stall_bad}, 32'd0);
    checkOutput("stall_at_ready", {31'd0, stall_req}, 32'd0);
    repeat (hold) @(negedge clk);
    checkOutput("ready_held", {31'd0, ready}, 32'd1);
    checkOutput("lo_held", result_lo, elo);
    checkOutput("hi_held", result_hi, ehi);
    start = 1'b0;
    @(negedge clk);
    checkOutput("ready_fall", {31'd0, ready}, 32'd0);
    checkOutput("lo_kept", result_lo, elo);
    checkOutput("hi_kept", result_hi, ehi);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic saw_ready;
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    #1;
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_lo", result_lo, 32'd0);
    checkOutput("reset_hi", result_hi, 32'd0);
    checkOutput("reset_stall", {31'd0, stall_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed divide vectors");
    applyStimulus(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 3);
    applyStimulus(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33, 0);
    applyStimulus(1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33, 1);
    applyStimulus(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33, 0);
    applyStimulus(1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33, 0);
    applyStimulus(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33, 0);
    applyStimulus(1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33, 0);
    applyStimulus(1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          33, 0);
    applyStimulus(1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2,  2);

    $display("[TB] annul during BUSY");
    applyStimulus(1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 33, 0);
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd4;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    checkOutput("annul_ready", {31'd0, ready}, 32'd0);
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
    end
    checkOutput("annul_no_ready", {31'd0, saw_ready}, 32'd0);
    checkOutput("annul_lo_kept", result_lo, 32'd142);
    checkOutput("annul_hi_kept", result_hi, 32'd6);
    applyStimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0);

    $display("[TB] asynchronous reset during BUSY");
    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
    @(negedge clk);
    start = 1'b1; opdata1 = 32'd77; opdata2 = 32'd5;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_lo", result_lo, 32'd0);
    checkOutput("async_rst_hi", result_hi, 32'd0);
    checkOutput("async_rst_ready", {31'd0, ready}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
    end
    checkOutput("rst_abort_no_ready", {31'd0, saw_ready}, 32'd0);

    $display("[TB] annul together with start in IDLE");
    @(negedge clk);
    start = 1'b1; annul = 1'b1; opdata1 = 32'd9; opdata2 = 32'd3;
    repeat (3) @(negedge clk);
    start = 1'b0; annul = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
    end
    checkOutput("annul_start_idle", {31'd0, saw_ready}, 32'd0);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) reportFailure("scoreboard_leftover");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
